// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, PC step and
// alignment constants, and the hard-wired zero register index.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    BWAIT  = 2'd2
  } state_t;

  // Byte increment between sequential instructions.
  localparam int unsigned PC_STEP = 4;

  // Register index that never carries a dependency.
  localparam int unsigned REG_ZERO = 0;

  // Low PC bits forced to zero on a redirect (word alignment).
  localparam int unsigned PC_ALIGN_LOW = 3;

endpackage

// File: rtl/fetch_sequencer_load_use_detect.sv
// Combinational load-use hazard detector: flags an instruction that reads
// the destination of the immediately preceding load.
module load_use_detect
  import fetch_seq_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic            last_load,
  input  logic [REGW-1:0] last_rd,
  input  logic            dec_valid,
  input  logic [REGW-1:0] dec_rs1,
  input  logic [REGW-1:0] dec_rs2,
  output logic            hazard
);

  // A load into the zero register produces nothing to wait for.
  always_comb begin
    hazard = last_load && (last_rd != REGW'(REG_ZERO)) && dec_valid &&
             ((dec_rs1 == last_rd) || (dec_rs2 == last_rd));
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one instruction per cycle to execute,
// inserts a single bubble on load-use hazards and serialises branches.
// Optional build macro FETCH_SEQ_PERF_EN adds saturating stall/redirect
// performance counters as extra outputs.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              REGW     = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_valid,
  input  logic [REGW-1:0] dec_rs1,
  input  logic [REGW-1:0] dec_rs2,
  input  logic [REGW-1:0] dec_rd,
  input  logic            dec_is_load,
  input  logic            dec_is_branch,
  input  logic            br_resolve,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] pc,
  output logic            stall,
  output logic            flush,
  output logic            issue_valid,
  output logic [XLEN-1:0] issue_pc
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_redirect_cnt
`endif
);

  state_t          state, next_state;
  logic [XLEN-1:0] next_pc, next_issue_pc, pc_inc, redirect_pc;
  logic            next_stall, next_flush, next_issue_valid;
  logic            last_load, next_last_load;
  logic [REGW-1:0] last_rd, next_last_rd;
  logic            hazard, accept;

  assign pc_inc      = pc + XLEN'(PC_STEP);
  assign redirect_pc = br_target & ~XLEN'(PC_ALIGN_LOW);

  load_use_detect #(.REGW(REGW)) u_hazard (
    .last_load (last_load),
    .last_rd   (last_rd),
    .dec_valid (dec_valid),
    .dec_rs1   (dec_rs1),
    .dec_rs2   (dec_rs2),
    .hazard    (hazard)
  );

  // Next-state and next-output logic; the hazard check only applies in RUN,
  // the held instruction in LSTALL is accepted unconditionally.
  always_comb begin
    next_state       = state;
    next_pc          = pc;
    next_stall       = 1'b0;
    next_flush       = 1'b0;
    next_issue_valid = 1'b0;
    next_issue_pc    = issue_pc;
    next_last_load   = last_load;
    next_last_rd     = last_rd;
    accept           = 1'b0;

    case (state)
      RUN: begin
        if (!dec_valid) begin
          next_last_load = 1'b0;
        end else if (hazard) begin
          next_stall     = 1'b1;
          next_last_load = 1'b0;
          next_state     = LSTALL;
        end else begin
          accept = 1'b1;
        end
      end
      LSTALL: begin
        if (dec_valid) accept = 1'b1;
        else           next_state = RUN;
      end
      BWAIT: begin
        if (br_resolve) begin
          next_state = RUN;
          if (br_taken) begin
            next_pc    = redirect_pc;
            next_flush = 1'b1;
          end else begin
            next_pc = pc_inc;
          end
        end
      end
      default: next_state = RUN;
    endcase

    if (accept) begin
      next_issue_valid = 1'b1;
      next_issue_pc    = pc;
      next_last_load   = dec_is_load;
      next_last_rd     = dec_rd;
      if (dec_is_branch) begin
        next_state     = BWAIT;
        next_last_load = 1'b0;
      end else begin
        next_state = RUN;
        next_pc    = pc_inc;
      end
    end
  end

  // State and output registers; reset wins over any pending branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      stall       <= 1'b0;
      flush       <= 1'b0;
      issue_valid <= 1'b0;
      issue_pc    <= '0;
      last_load   <= 1'b0;
      last_rd     <= '0;
    end else begin
      state       <= next_state;
      pc          <= next_pc;
      stall       <= next_stall;
      flush       <= next_flush;
      issue_valid <= next_issue_valid;
      issue_pc    <= next_issue_pc;
      last_load   <= next_last_load;
      last_rd     <= next_last_rd;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Stall counter covers LSTALL entries and every cycle spent in BWAIT;
  // redirect counter covers taken branch resolutions.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if ((state == RUN && hazard) || state == BWAIT)
        perf_stall_cnt <= sat_inc(perf_stall_cnt);
      if (state == BWAIT && br_resolve && br_taken)
        perf_redirect_cnt <= sat_inc(perf_redirect_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a random
// program run, all checked against a behavioural model of the sequencer.
module tb_fetch_sequencer;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            dec_valid;
  logic [REGW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic            dec_is_load, dec_is_branch;
  logic            br_resolve, br_taken;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] pc, issue_pc;
  logic            stall, flush, issue_valid;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0]     perf_stall_cnt, perf_redirect_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [XLEN-1:0] m_pc, m_ipc;
  logic            m_stall, m_flush, m_iv;
  logic            m_prev_load, m_in_bubble, m_wait_branch;
  logic [REGW-1:0] m_prev_rd;

  // Random program image, indexed by word address bits
  logic            p_valid [64];
  logic [REGW-1:0] p_rs1 [64], p_rs2 [64], p_rd [64];
  logic            p_load [64], p_branch [64];

  fetch_sequencer #(.XLEN(XLEN), .RESET_PC(32'h0), .REGW(REGW)) dut (
    .clk           (clk),
    .reset         (reset),
    .dec_valid     (dec_valid),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .dec_rd        (dec_rd),
    .dec_is_load   (dec_is_load),
    .dec_is_branch (dec_is_branch),
    .br_resolve    (br_resolve),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .pc            (pc),
    .stall         (stall),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_pc      (issue_pc)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_dec(input logic v, input int rs1, input int rs2,
                         input int rd, input logic ld, input logic br);
    dec_valid     = v;
    dec_rs1       = REGW'(rs1);
    dec_rs2       = REGW'(rs2);
    dec_rd        = REGW'(rd);
    dec_is_load   = ld;
    dec_is_branch = br;
  endtask

  task automatic set_br(input logic res, input logic tk, input logic [XLEN-1:0] tgt);
    br_resolve = res;
    br_taken   = tk;
    br_target  = tgt;
  endtask

  // Advance the model by one clock using the inputs as they stand, then let
  // the DUT take the same edge and settle.
  task automatic step();
    logic dep;
    if (reset) begin
      m_pc = 32'h0; m_ipc = '0; m_stall = 0; m_flush = 0; m_iv = 0;
      m_prev_load = 0; m_prev_rd = '0; m_in_bubble = 0; m_wait_branch = 0;
    end else if (m_wait_branch) begin
      m_iv = 0; m_stall = 0; m_flush = 0;
      if (br_resolve) begin
        m_wait_branch = 0;
        if (br_taken) begin
          m_pc    = {br_target[XLEN-1:2], 2'b00};
          m_flush = 1;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end else begin
      dep = !m_in_bubble && m_prev_load && m_prev_rd != 0 && dec_valid &&
            (dec_rs1 == m_prev_rd || dec_rs2 == m_prev_rd);
      m_iv = 0; m_stall = 0; m_flush = 0;
      if (!dec_valid) begin
        m_prev_load = 0; m_in_bubble = 0;
      end else if (dep) begin
        m_stall = 1; m_prev_load = 0; m_in_bubble = 1;
      end else begin
        m_iv = 1; m_ipc = m_pc; m_in_bubble = 0;
        m_prev_load = dec_is_load; m_prev_rd = dec_rd;
        if (dec_is_branch) begin
          m_wait_branch = 1; m_prev_load = 0;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    set_dec(1, 0, 0, 0, 0, 0);
    set_br(0, 0, '0);
    step();
    step();
    total++;
    if ({pc, stall, flush, issue_valid, issue_pc} !== {32'h0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_state got pc=%h st=%b fl=%b iv=%b ipc=%h want all zero",
               pc, stall, flush, issue_valid, issue_pc);
    end
  endtask

  task automatic test_sequential();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      set_dec(1, 1, 2, 3, 0, 0);
      step();
      total++;
      if (pc !== 32'(4 * (i + 1)) || issue_valid !== 1'b1 || issue_pc !== 32'(4 * i)) begin
        bad++;
        $display("FAIL seq_issue[%0d] got pc=%h iv=%b ipc=%h want pc=%h iv=1 ipc=%h",
                 i, pc, issue_valid, issue_pc, 32'(4 * (i + 1)), 32'(4 * i));
      end
    end
    set_dec(1, 1, 2, 3, 0, 0);
    step();
  endtask

  task automatic test_load_use();
    // load x5 at 0x10, consumer at 0x14, then an rd=0 load that must not stall
    set_dec(1, 1, 2, 5, 1, 0); step();
    set_dec(1, 5, 7, 6, 0, 0); step();
    total++;
    if (stall !== 1'b1 || pc !== 32'h14 || issue_valid !== 1'b0 ||
        {pc, stall, flush, issue_valid, issue_pc} !== {m_pc, m_stall, m_flush, m_iv, m_ipc}) begin
      bad++;
      $display("FAIL lu_stall got st=%b pc=%h iv=%b want st=1 pc=00000014 iv=0",
               stall, pc, issue_valid);
    end
    step();
    total++;
    if (stall !== 1'b0 || issue_valid !== 1'b1 || issue_pc !== 32'h14 || pc !== 32'h18) begin
      bad++;
      $display("FAIL lu_release got st=%b iv=%b ipc=%h pc=%h want st=0 iv=1 ipc=00000014 pc=00000018",
               stall, issue_valid, issue_pc, pc);
    end
    set_dec(1, 1, 2, 0, 1, 0); step();
    set_dec(1, 0, 0, 4, 0, 0); step();
    total++;
    if (stall !== 1'b0 || issue_valid !== 1'b1 || pc !== 32'h20) begin
      bad++;
      $display("FAIL lu_rd0 got st=%b iv=%b pc=%h want st=0 iv=1 pc=00000020",
               stall, issue_valid, pc);
    end
  endtask

  task automatic test_branch_taken();
    set_dec(1, 1, 2, 0, 0, 1); step();
    total++;
    if (pc !== 32'h20 || issue_valid !== 1'b1 || issue_pc !== 32'h20) begin
      bad++;
      $display("FAIL br_issue got pc=%h iv=%b ipc=%h want pc=00000020 iv=1 ipc=00000020",
               pc, issue_valid, issue_pc);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (pc !== 32'h20 || issue_valid !== 1'b0 || flush !== 1'b0) begin
        bad++;
        $display("FAIL br_wait[%0d] got pc=%h iv=%b fl=%b want pc=00000020 iv=0 fl=0",
                 i, pc, issue_valid, flush);
      end
    end
    set_br(1, 1, 32'h103); step();
    set_br(0, 0, '0);
    total++;
    if (pc !== 32'h100 || flush !== 1'b1 || issue_valid !== 1'b0) begin
      bad++;
      $display("FAIL br_taken got pc=%h fl=%b iv=%b want pc=00000100 fl=1 iv=0",
               pc, flush, issue_valid);
    end
    set_dec(1, 1, 2, 3, 0, 0); step();
    total++;
    if (flush !== 1'b0 || pc !== 32'h104 || issue_pc !== 32'h100) begin
      bad++;
      $display("FAIL br_flush_end got fl=%b pc=%h ipc=%h want fl=0 pc=00000104 ipc=00000100",
               flush, pc, issue_pc);
    end
  endtask

  task automatic test_branch_not_taken();
    // reach 0x40 through a taken branch, then resolve the 0x40 branch not-taken
    set_dec(1, 0, 0, 0, 0, 1); step();
    set_br(1, 1, 32'h40); step();
    set_br(0, 0, '0);
    step();
    set_br(1, 0, 32'h800); step();
    set_br(0, 0, '0);
    total++;
    if (pc !== 32'h44 || flush !== 1'b0 || issue_valid !== 1'b0) begin
      bad++;
      $display("FAIL br_not_taken got pc=%h fl=%b iv=%b want pc=00000044 fl=0 iv=0",
               pc, flush, issue_valid);
    end
  endtask

  task automatic test_spurious_wrap();
    set_dec(1, 0, 0, 0, 0, 1); step();
    set_br(1, 1, 32'hFFFF_FFFE); step();
    total++;
    if (pc !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_setup got pc=%h want fffffffc", pc);
    end
    set_dec(1, 0, 0, 0, 0, 0);
    set_br(1, 1, 32'h500); step();
    set_br(0, 0, '0);
    total++;
    if (pc !== 32'h0 || flush !== 1'b0 || issue_pc !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_spurious got pc=%h fl=%b ipc=%h want pc=00000000 fl=0 ipc=fffffffc",
               pc, flush, issue_pc);
    end
  endtask

  task automatic test_reset_bwait();
    set_dec(1, 0, 0, 0, 0, 1); step();
    step();
    reset = 1;
    set_br(1, 1, 32'h300); step();
    reset = 0;
    set_br(0, 0, '0);
    total++;
    if (pc !== 32'h0 || flush !== 1'b0 || issue_valid !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_bwait got pc=%h fl=%b iv=%b st=%b want pc=0 fl=0 iv=0 st=0",
               pc, flush, issue_valid, stall);
    end
    set_dec(1, 1, 2, 3, 0, 0); step();
    total++;
    if (pc !== 32'h4 || issue_valid !== 1'b1 || issue_pc !== 32'h0) begin
      bad++;
      $display("FAIL rst_bwait_run got pc=%h iv=%b ipc=%h want pc=00000004 iv=1 ipc=00000000",
               pc, issue_valid, issue_pc);
    end
  endtask

  task automatic test_random();
    int idx;
    for (int i = 0; i < 64; i++) begin
      p_valid[i]  = ($urandom_range(0, 9) != 0);
      p_rs1[i]    = REGW'($urandom_range(0, 3));
      p_rs2[i]    = REGW'($urandom_range(0, 3));
      p_rd[i]     = REGW'($urandom_range(0, 3));
      p_load[i]   = ($urandom_range(0, 9) < 3);
      p_branch[i] = ($urandom_range(0, 19) < 3);
    end
    for (int c = 0; c < 600; c++) begin
      idx           = int'(pc[7:2]);
      reset         = ($urandom_range(0, 99) < 2);
      dec_valid     = p_valid[idx];
      dec_rs1       = p_rs1[idx];
      dec_rs2       = p_rs2[idx];
      dec_rd        = p_rd[idx];
      dec_is_load   = p_load[idx];
      dec_is_branch = p_branch[idx];
      br_resolve    = ($urandom_range(0, 9) < 3);
      br_taken      = $urandom_range(0, 1) == 1;
      br_target     = {24'h0, 8'($urandom)};
      step();
      total++;
      if ({pc, stall, flush, issue_valid, issue_pc} !== {m_pc, m_stall, m_flush, m_iv, m_ipc}) begin
        bad++;
        $display("FAIL rand[%0d] got pc=%h st=%b fl=%b iv=%b ipc=%h want pc=%h st=%b fl=%b iv=%b ipc=%h",
                 c, pc, stall, flush, issue_valid, issue_pc, m_pc, m_stall, m_flush, m_iv, m_ipc);
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1;
    set_dec(0, 0, 0, 0, 0, 0);
    set_br(0, 0, '0);
    #1;
    test_reset();
    test_sequential();
    test_load_use();
    test_branch_taken();
    test_branch_not_taken();
    test_spurious_wrap();
    test_reset_bwait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
